// File: rtl/store_merge_unit.sv
// Store path to a word-wide memory without byte enables: SB/SH go through a
// read-modify-write of the addressed word, SW is written directly.
module store_merge_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WIDTH-1:0]      inst,
    input  logic [WIDTH-1:0]      addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  done,
    output logic                  err
);

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        RESP
    } state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic                  done_q;
    logic                  err_q;
    logic [1:0]            lane_q;
    logic                  is_sh_q;
    logic [WIDTH-1:0]      wbuf_q;
    logic [WIDTH-1:0]      wbuf_d;
    logic [2:0]            funct3_c;
    logic                  illegal_c;
    logic                  unused_c;

    assign funct3_c = inst[14:12];
    assign unused_c = ^{inst[WIDTH-1:15], inst[11:7], addr[WIDTH-1:ADDR_WIDTH+2]};

    // Request legality: store opcode, known width, natural alignment
    always_comb begin
        illegal_c = 1'b0;
        if (inst[6:0] != OPC_STORE) begin
            illegal_c = 1'b1;
        end else begin
            case (funct3_c)
                F3_SB:   illegal_c = 1'b0;
                F3_SH:   illegal_c = addr[0];
                F3_SW:   illegal_c = (addr[1:0] != 2'b00);
                default: illegal_c = 1'b1;
            endcase
        end
    end

    // Replace the addressed lane of the read word with the buffered store data
    always_comb begin
        wbuf_d = mem_rdata;
        if (is_sh_q) begin
            if (lane_q[1]) wbuf_d[31:16] = wbuf_q[15:0];
            else           wbuf_d[15:0]  = wbuf_q[15:0];
        end else begin
            case (lane_q)
                2'd0: wbuf_d[7:0]   = wbuf_q[7:0];
                2'd1: wbuf_d[15:8]  = wbuf_q[7:0];
                2'd2: wbuf_d[23:16] = wbuf_q[7:0];
                2'd3: wbuf_d[31:24] = wbuf_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lane_q      <= 2'b00;
            is_sh_q     <= 1'b0;
            wbuf_q      <= '0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        mem_addr_q  <= addr[ADDR_WIDTH+1:2];
                        lane_q      <= addr[1:0];
                        is_sh_q     <= inst[12];
                        wbuf_q      <= wdata;
                        if (illegal_c) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (funct3_c == F3_SW) begin
                            state_q     <= WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata;
                        end else begin
                            state_q  <= RD;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                RD: state_q <= MRG;
                MRG: begin
                    state_q     <= WR;
                    wbuf_q      <= wbuf_d;
                    mem_wdata_q <= wbuf_d;
                    mem_we_q    <= 1'b1;
                end
                WR: begin
                    state_q <= RESP;
                    done_q  <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: word memory model, directed store cases, reset abort,
// back-to-back SWs, then random stores checked against a lane-arithmetic reference.
module tb_store_merge_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_re;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic             done;
    logic             err;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    int checks = 0;
    int errors = 0;

    store_merge_unit #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .inst(inst), .addr(addr), .wdata(wdata), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Data memory without byte enables, one-cycle read latency
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] opc);
        logic [31:0] v;
        v = $urandom;
        v[6:0]   = opc;
        v[14:12] = f3;
        return v;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // One store: reference outcome from lane arithmetic, then observe the DUT cycle by cycle
    task automatic run_store(input string tag, input logic [31:0] inst_v,
                             input logic [31:0] addr_v, input logic [31:0] wd_v);
        int          idx, f3, shift, exp_done, exp_re_cnt, exp_we_cyc;
        bit          legal;
        logic [31:0] old_w, exp_w, mask;
        int          re_cnt, we_cnt, re_cyc, we_cyc, done_cyc;
        logic [7:0]  re_addr, we_addr;
        logic [31:0] we_data;
        logic        err_at;
        bit          ready_bad, overlap;

        idx   = int'(addr_v[9:2]);
        f3    = int'(inst_v[14:12]);
        legal = (inst_v[6:0] == 7'h23) &&
                ((f3 == 0) || (f3 == 1 && addr_v[0] == 1'b0) || (f3 == 2 && addr_v[1:0] == 2'b00));
        old_w = ref_mem[idx];
        exp_w = old_w;
        if (legal) begin
            if (f3 == 0) begin
                shift = 8 * int'(addr_v[1:0]);
                mask  = 32'hFF << shift;
                exp_w = (old_w & ~mask) | ((wd_v & 32'hFF) << shift);
            end else if (f3 == 1) begin
                shift = 16 * int'(addr_v[1]);
                mask  = 32'hFFFF << shift;
                exp_w = (old_w & ~mask) | ((wd_v & 32'hFFFF) << shift);
            end else begin
                exp_w = wd_v;
            end
            ref_mem[idx] = exp_w;
        end
        exp_done   = !legal ? 1 : (f3 == 2 ? 2 : 4);
        exp_we_cyc = (f3 == 2) ? 1 : 3;
        exp_re_cnt = (legal && f3 != 2) ? 1 : 0;

        @(negedge clk);
        check({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        inst      = inst_v;
        addr      = addr_v;
        wdata     = wd_v;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        inst      = $urandom;
        addr      = $urandom;
        wdata     = $urandom;

        re_cnt = 0; we_cnt = 0; re_cyc = 0; we_cyc = 0; done_cyc = 0;
        re_addr = '0; we_addr = '0; we_data = '0; err_at = 1'b0;
        ready_bad = 1'b0; overlap = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (req_ready) ready_bad = 1'b1;
            if (mem_re && mem_we) overlap = 1'b1;
            if (mem_re) begin
                re_cnt++;
                if (re_cyc == 0) begin re_cyc = c; re_addr = mem_addr; end
            end
            if (mem_we) begin
                we_cnt++;
                if (we_cyc == 0) begin we_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
            end
            if (done) begin
                done_cyc = c;
                err_at   = err;
                break;
            end
        end

        check({tag, ":done_cyc"}, 32'(done_cyc), 32'(exp_done));
        check({tag, ":err"}, 32'(err_at), 32'(!legal));
        check({tag, ":re_cnt"}, 32'(re_cnt), 32'(exp_re_cnt));
        check({tag, ":we_cnt"}, 32'(we_cnt), 32'(legal));
        check({tag, ":busy_ready"}, 32'(ready_bad), 32'd0);
        check({tag, ":re_we_overlap"}, 32'(overlap), 32'd0);
        if (exp_re_cnt != 0) begin
            check({tag, ":re_cyc"}, 32'(re_cyc), 32'd1);
            check({tag, ":re_addr"}, 32'(re_addr), 32'(idx));
        end
        if (legal) begin
            check({tag, ":we_cyc"}, 32'(we_cyc), 32'(exp_we_cyc));
            check({tag, ":we_addr"}, 32'(we_addr), 32'(idx));
            check({tag, ":we_data"}, we_data, exp_w);
        end
        check({tag, ":mem"}, mem[idx], ref_mem[idx]);
    endtask

    task automatic reset_abort_test();
        bit we_seen;
        preload(8'h10, 32'hAABBCCDD);
        @(negedge clk);
        req_valid = 1'b1;
        inst      = mk_inst(3'b000, 7'h23);
        addr      = 32'h41;
        wdata     = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst:rd_re", 32'(mem_re), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst:mem_re", 32'(mem_re), 32'd0);
        check("rst:mem_we", 32'(mem_we), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:err", 32'(err), 32'd0);
        check("rst:mem_addr", 32'(mem_addr), 32'd0);
        check("rst:mem_wdata", mem_wdata, 32'd0);
        we_seen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_we) we_seen = 1'b1;
        end
        check("rst:no_we", 32'(we_seen), 32'd0);
        check("rst:ready", 32'(req_ready), 32'd1);
        check("rst:mem_word", mem[8'h10], 32'hAABBCCDD);
    endtask

    task automatic back_to_back_test();
        int          n_acc, n_we;
        int          we_c [2];
        logic [7:0]  we_a [2];
        bit          acc;
        n_acc = 0; n_we = 0;
        we_c[0] = 0; we_c[1] = 0; we_a[0] = '0; we_a[1] = '0;
        @(negedge clk);
        req_valid = 1'b1;
        inst      = mk_inst(3'b010, 7'h23);
        addr      = 32'h80;
        wdata     = 32'h11112222;
        for (int c = 0; c < 12; c++) begin
            acc = req_ready && req_valid;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    inst  = mk_inst(3'b010, 7'h23);
                    addr  = 32'h84;
                    wdata = 32'h33334444;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (mem_we) begin
                if (n_we < 2) begin we_c[n_we] = c; we_a[n_we] = mem_addr; end
                n_we++;
            end
        end
        ref_mem[8'h20] = 32'h11112222;
        ref_mem[8'h21] = 32'h33334444;
        check("b2b:accepts", 32'(n_acc), 32'd2);
        check("b2b:we_pulses", 32'(n_we), 32'd2);
        check("b2b:we_spacing", 32'(we_c[1] - we_c[0]), 32'd3);
        check("b2b:addr0", 32'(we_a[0]), 32'h20);
        check("b2b:addr1", 32'(we_a[1]), 32'h21);
        check("b2b:mem20", mem[8'h20], 32'h11112222);
        check("b2b:mem21", mem[8'h21], 32'h33334444);
    endtask

    initial begin
        logic [31:0] ri, ra;
        int          r;
        reset     = 1'b1;
        req_valid = 1'b0;
        inst      = '0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) preload(i, 32'(i) * 32'h01010101);
        repeat (2) @(negedge clk);
        check("reset:ready", 32'(req_ready), 32'd1);
        check("reset:mem_re", 32'(mem_re), 32'd0);
        check("reset:mem_we", 32'(mem_we), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:err", 32'(err), 32'd0);
        check("reset:mem_addr", 32'(mem_addr), 32'd0);
        check("reset:mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        preload(8'h10, 32'hAABBCCDD);
        run_store("sb41", mk_inst(3'b000, 7'h23), 32'h41, 32'h12345678);
        check("sb41:word", mem[8'h10], 32'hAABB78DD);
        preload(8'h10, 32'hAABBCCDD);
        run_store("sh42", mk_inst(3'b001, 7'h23), 32'h42, 32'hFFFFBEEF);
        check("sh42:word", mem[8'h10], 32'hBEEFCCDD);
        preload(8'h10, 32'hAABBCCDD);
        run_store("sh40", mk_inst(3'b001, 7'h23), 32'h40, 32'hFFFFBEEF);
        check("sh40:word", mem[8'h10], 32'hAABBBEEF);
        run_store("sw44", mk_inst(3'b010, 7'h23), 32'h44, 32'hDEADBEEF);
        check("sw44:word", mem[8'h11], 32'hDEADBEEF);
        preload(8'h10, 32'hAABBCCDD);
        run_store("sh43", mk_inst(3'b001, 7'h23), 32'h43, 32'h0000CAFE);
        check("sh43:word", mem[8'h10], 32'hAABBCCDD);
        run_store("load_opc", mk_inst(3'b010, 7'b0000011), 32'h40, 32'h55555555);
        check("load_opc:word", mem[8'h10], 32'hAABBCCDD);
        run_store("sb_top", mk_inst(3'b000, 7'h23), 32'hABCD03FF, 32'h000000A5);
        check("sb_top:word", mem[8'hFF][31:24], 32'hA5);

        reset_abort_test();
        back_to_back_test();

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      ri = mk_inst(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)) ^ 7'h40);
            else if (r == 1) ri = mk_inst(3'($urandom_range(3, 7)), 7'h23);
            else             ri = mk_inst(3'($urandom_range(0, 2)), 7'h23);
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            run_store($sformatf("rnd%0d", n), ri, ra, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load data extraction path. It takes a decoded store (SB/SH/SW) and writes it into a word-wide data memory that has no byte enables.
- SB and SH are done as a read-modify-write. The addressed byte or halfword lane is replaced with the low bits of rs2 data. SW is written directly.
- Sits between the execute stage and the data memory port. It stalls the core through req_ready until the store retires.

Parameters:
- WIDTH, 32, data and instruction width.
- ADDR_WIDTH, 8, memory word-index width (memory depth 2^ADDR_WIDTH words).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit idle and able to accept a request.
- inst  input  WIDTH  store instruction; opcode inst[6:0], funct3 inst[14:12].
- addr  input  WIDTH  byte address (rs1 + imm).
- wdata  input  WIDTH  rs2 value.
- mem_addr  output  ADDR_WIDTH  word index, addr_q[ADDR_WIDTH+1:2].
- mem_re  output  1  memory read strobe.
- mem_rdata  input  WIDTH  read data, valid the cycle after mem_re (1-cycle latency).
- mem_we  output  1  memory write strobe.
- mem_wdata  output  WIDTH  word to write.
- done  output  1  one-cycle pulse, store retired.
- err  output  1  qualifies done; request rejected with no memory write.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; req_ready=1; mem_re, mem_we, done, err = 0; mem_addr and mem_wdata = 0; internal registers cleared.
- Reset asserted mid-operation aborts the store. No write occurs unless WR had already completed a clock edge.
- Accept: req_valid && req_ready at a rising edge. On accept, inst, addr and wdata are registered.
- req_valid while busy is ignored. Input changes after accept have no effect.
- Illegal request sets err:
  - opcode != 7'b0100011, or
  - funct3 not in {000, 001, 010}, or
  - SH with addr[0]=1, or
  - SW with addr[1:0] != 0.
- States:
  - IDLE: req_ready=1. On accept: illegal -> RESP with err latched; SW -> WR with wbuf=wdata; SB/SH -> RD.
  - RD: mem_re=1, mem_addr=word index -> MRG.
  - MRG: capture mem_rdata and merge into wbuf -> WR.
  - WR: mem_we=1, mem_wdata=wbuf, mem_addr=word index -> RESP.
  - RESP: done=1, err=latched flag -> IDLE.
- req_ready=0 in every state except IDLE. mem_re and mem_we are never high together. mem_addr is held stable from RD through WR.
- Merge rules, with lane = addr_q[1:0]:
  - SB: wbuf = rdata with bits [8*lane+7 : 8*lane] replaced by wdata[7:0].
  - SH: lane addr_q[1] selects bits [15:0] or [31:16], replaced by wdata[15:0].
  - Unused wdata bits are ignored; no sign extension on stores.
- Latency, counted from the accept edge (cycle 0):
  - SW: WR at cycle 1, done at cycle 2.
  - SB/SH: RD 1, MRG 2, WR 3, done 4.
  - Illegal: done+err at cycle 1, with zero mem_re/mem_we activity.
- Back-to-back: the next accept is possible in the cycle after RESP (IDLE). A minimum SW throughput of one store every 3 cycles is required.
- Word-index wrap: upper address bits above ADDR_WIDTH+1 are ignored. Index 2^ADDR_WIDTH-1 is a valid target with no special handling.

Test Plan:
- Preload word 0x10 = 0xAABBCCDD; SB (funct3 000) addr 0x41 wdata 0x12345678 -> mem_re cycle 1 idx 0x10; mem_we cycle 3 mem_wdata 0xAABB78DD; done cycle 4, err=0.
- Same preload; SH addr 0x42 wdata 0xFFFFBEEF -> mem_we cycle 3 mem_wdata 0xBEEFCCDD; lane 0 variant addr 0x40 -> 0xAABBBEEF.
- SW addr 0x44 wdata 0xDEADBEEF -> mem_re never high; mem_we cycle 1 idx 0x11 data 0xDEADBEEF; done cycle 2; req_ready low cycles 1-2.
- SH addr 0x43, and separately opcode 0000011 -> done=1 and err=1 at cycle 1; mem_re and mem_we stay 0; memory unchanged.
- Assert reset during MRG of an SB -> all outputs 0 immediately, no mem_we, memory word unchanged, req_ready=1 after release.
- req_valid held high with two queued SWs (idx 0x20, 0x21) -> second accepted only after first done; exactly two mem_we pulses, 3 cycles apart.
